// File: rtl/pdm_deserializer.sv
// PDM microphone front end: divides the system clock into pdm_clk and packs the 1-bit stream into WIDTH-bit words.
// Define PDM_DESERIALIZER_SYNC_EN to put a 2-flop synchronizer ahead of the pdm_data sample register.
module pdm_deserializer #(
    parameter int WIDTH        = 16,
    parameter int CLOCK_DIVIDE = 10,
    parameter int CHANNEL      = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    output logic             done,
    output logic [WIDTH-1:0] data,
    output logic             pdm_clk,
    input  logic             pdm_data,
    output logic             pdm_lr
);

    localparam int DIV_W = $clog2(CLOCK_DIVIDE);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic CAPTURE_LEVEL = (CHANNEL != 0);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-2:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             pdm_clk_q, pdm_clk_d;
    logic             done_q, done_d;
    logic             sample_q;
    logic             toggle;
    logic             capture;

    assign pdm_lr  = CAPTURE_LEVEL;
    assign pdm_clk = pdm_clk_q;
    assign done    = done_q;
    assign data    = data_q;

`ifdef PDM_DESERIALIZER_SYNC_EN
    logic sync1_q, sync2_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            sample_q <= 1'b0;
        end else begin
            sync1_q  <= pdm_data;
            sync2_q  <= sync1_q;
            sample_q <= sync2_q;
        end
    end
`else
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sample_q <= 1'b0;
        end else begin
            sample_q <= pdm_data;
        end
    end
`endif

    always_comb begin
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        pdm_clk_d = pdm_clk_q;
        done_d    = 1'b0;
        toggle    = 1'b0;
        capture   = 1'b0;
        if (!enable) begin
            // Idle discards any partial word but keeps the last completed one.
            div_cnt_d = '0;
            bit_cnt_d = '0;
            shift_d   = '0;
            pdm_clk_d = 1'b0;
        end else begin
            toggle    = (div_cnt_q == DIV_W'(CLOCK_DIVIDE - 1));
            div_cnt_d = toggle ? '0 : div_cnt_q + 1'b1;
            if (toggle) begin
                pdm_clk_d = ~pdm_clk_q;
            end
            // Capture on the toggle that leaves the level the selected channel samples at.
            capture = toggle && (pdm_clk_q == CAPTURE_LEVEL);
            if (capture) begin
                if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
                    data_d    = {shift_q, sample_q};
                    done_d    = 1'b1;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end else begin
                    shift_d    = shift_q << 1;
                    shift_d[0] = sample_q;
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            pdm_clk_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            pdm_clk_q <= pdm_clk_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_pdm_deserializer.sv
// Bench for pdm_deserializer: default instance plus a CHANNEL=0, CLOCK_DIVIDE=2, WIDTH=4 instance, scoreboard-checked.
module tb_pdm_deserializer;

    typedef struct {
        int          at;
        logic [31:0] word;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        en0 = 1'b0;
    logic        pd0 = 1'b0;
    logic        done0;
    logic [15:0] data0;
    logic        pclk0;
    logic        lr0;
    logic        en1 = 1'b0;
    logic        pd1 = 1'b0;
    logic        done1;
    logic [3:0]  data1;
    logic        pclk1;
    logic        lr1;

    int cyc = 0;
    int base = 0;
    int passed = 0;
    int total = 0;
    exp_t q0[$];
    exp_t q1[$];

    pdm_deserializer dut0 (
        .clock(clock), .reset(reset), .enable(en0), .done(done0), .data(data0),
        .pdm_clk(pclk0), .pdm_data(pd0), .pdm_lr(lr0)
    );

    pdm_deserializer #(.WIDTH(4), .CLOCK_DIVIDE(2), .CHANNEL(0)) dut1 (
        .clock(clock), .reset(reset), .enable(en1), .done(done1), .data(data1),
        .pdm_clk(pclk1), .pdm_data(pd1), .pdm_lr(lr1)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard: every done strobe must match the next expected word and edge.
    always @(negedge clock) begin
        exp_t e;
        if (done0 === 1'b1) begin
            if (q0.size() == 0) begin
                total++;
                $display("FAIL dut0_unexpected_done at edge %0d data=%h", cyc - base, data0);
            end else begin
                e = q0.pop_front();
                total++;
                if (data0 !== e.word[15:0])
                    $display("FAIL dut0_word got=%h expected=%h", data0, e.word[15:0]);
                else passed++;
                total++;
                if (cyc !== e.at)
                    $display("FAIL dut0_done_edge got=%0d expected=%0d", cyc - base, e.at - base);
                else passed++;
            end
        end
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                total++;
                $display("FAIL dut1_unexpected_done at edge %0d data=%h", cyc - base, data1);
            end else begin
                e = q1.pop_front();
                total++;
                if (data1 !== e.word[3:0])
                    $display("FAIL dut1_word got=%h expected=%h", data1, e.word[3:0]);
                else passed++;
                total++;
                if (cyc !== e.at)
                    $display("FAIL dut1_done_edge got=%0d expected=%0d", cyc - base, e.at - base);
                else passed++;
            end
        end
    end

    // Edge 0 is the edge just before enable rises; edge 1 is the first edge that sees enable=1.
    task automatic mark_base();
        @(posedge clock);
        #1;
        base = cyc;
    endtask

    task automatic wait_edge(input int n);
        while (cyc < base + n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic go_idle();
        en0 = 1'b0;
        en1 = 1'b0;
        repeat (5) @(posedge clock);
    endtask

    task automatic push0(input int rel, input logic [31:0] w);
        exp_t e;
        e.at = base + rel;
        e.word = w;
        q0.push_back(e);
    endtask

    task automatic check_q0_empty(input string name);
        total++;
        if (q0.size() != 0) $display("FAIL %s_missing_done pending=%0d expected=0", name, q0.size());
        else passed++;
    endtask

    task automatic test_reset();
        en0 = 1'b1;
        pd0 = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        total++;
        if ({pclk0, done0, data0, lr0} !== {1'b0, 1'b0, 16'h0000, 1'b1})
            $display("FAIL reset_hold got clk=%b done=%b data=%h lr=%b expected 0 0 0000 1", pclk0, done0, data0, lr0);
        else passed++;
        reset = 1'b0;
        mark_base();
        wait_edge(15);
        total++;
        if (pclk0 !== 1'b1) $display("FAIL run_pdm_clk_high got=%b expected=1", pclk0);
        else passed++;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (pclk0 !== 1'b0) $display("FAIL async_reset_clk got=%b expected=0", pclk0);
        else passed++;
        repeat (20) @(posedge clock);
        #1;
        total++;
        if ({pclk0, done0, data0} !== {1'b0, 1'b0, 16'h0000})
            $display("FAIL reset_held got clk=%b done=%b data=%h expected 0 0 0000", pclk0, done0, data0);
        else passed++;
        en0 = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(posedge clock);
    endtask

    task automatic test_all_ones();
        pd0 = 1'b1;
        mark_base();
        en0 = 1'b1;
        push0(320, 32'hFFFF);
        push0(640, 32'hFFFF);
        wait_edge(319);
        total++;
        if (data0 !== 16'h0000) $display("FAIL ones_data_before_done got=%h expected=0000", data0);
        else passed++;
        wait_edge(321);
        total++;
        if (done0 !== 1'b0) $display("FAIL ones_done_width got=%b expected=0", done0);
        else passed++;
        wait_edge(641);
        check_q0_empty("ones");
        go_idle();
    endtask

    task automatic test_alternating();
        pd0 = 1'b1;
        mark_base();
        en0 = 1'b1;
        push0(320, 32'hAAAA);
        for (int i = 1; i <= 16; i++) begin
            wait_edge(20 * i);
            pd0 = ~pd0;
        end
        wait_edge(321);
        check_q0_empty("alternating");
        go_idle();
    endtask

    task automatic test_enable_drop();
        pd0 = 1'b0;
        mark_base();
        en0 = 1'b1;
        wait_edge(160);
        en0 = 1'b0;
        repeat (40) @(posedge clock);
        #1;
        total++;
        if ({pclk0, data0} !== {1'b0, 16'hAAAA})
            $display("FAIL drop_idle got clk=%b data=%h expected 0 aaaa", pclk0, data0);
        else passed++;
        mark_base();
        en0 = 1'b1;
        push0(320, 32'h0000);
        wait_edge(319);
        total++;
        if (data0 !== 16'hAAAA) $display("FAIL drop_data_hold got=%h expected=aaaa", data0);
        else passed++;
        wait_edge(321);
        check_q0_empty("enable_drop");
        go_idle();
    endtask

    task automatic test_late_ones();
        pd0 = 1'b0;
        mark_base();
        en0 = 1'b1;
        push0(320, 32'h7FFF);
        wait_edge(25);
        pd0 = 1'b1;
        wait_edge(321);
        check_q0_empty("late_ones");
        go_idle();
    endtask

    task automatic test_channel0();
        exp_t e;
        pd1 = 1'b1;
        mark_base();
        en1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            e.at = base + 14 + 16 * i;
            e.word = 32'hF;
            q1.push_back(e);
        end
        total++;
        if (lr1 !== 1'b0) $display("FAIL ch0_lr got=%b expected=0", lr1);
        else passed++;
        wait_edge(2);
        total++;
        if (pclk1 !== 1'b1) $display("FAIL ch0_clk_rise got=%b expected=1", pclk1);
        else passed++;
        wait_edge(4);
        total++;
        if (pclk1 !== 1'b0) $display("FAIL ch0_clk_fall got=%b expected=0", pclk1);
        else passed++;
        wait_edge(6);
        total++;
        if (pclk1 !== 1'b1) $display("FAIL ch0_clk_period got=%b expected=1", pclk1);
        else passed++;
        wait_edge(47);
        total++;
        if (q1.size() != 0) $display("FAIL ch0_missing_done pending=%0d expected=0", q1.size());
        else passed++;
        go_idle();
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_alternating();
        test_enable_drop();
        test_late_ones();
        test_channel0();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
